// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, select/state enums and the forwarding priority helper for hazard_ctrl_unit
package hazard_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, FLUSH = 2'd2} hz_state_e;
  function automatic fwd_sel_e fwd_pick(input logic used, input logic [4:0] src,
                                        input logic ex_ok, input logic [4:0] ex_rd,
                                        input logic mem_ok, input logic [4:0] mem_rd);
    return !used ? FWD_RF : (ex_ok && src == ex_rd) ? FWD_EX : (mem_ok && src == mem_rd) ? FWD_MEM : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_unit_src_decode.sv
// hazard_src_decode: extracts register fields and operand usage from one RV32I instruction
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        is_load
);
  logic [6:0] op;
  logic unused_bits;
  assign op = ir[6:0];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd = ir[11:7];
  assign rs1_used = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign rs2_used = op == OP_R || op == OP_S || op == OP_B;
  assign is_load = op == OP_LOAD;
  assign unused_bits = ^{ir[31:25], ir[14:12]};
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RV32I forwarding/stall/flush controller; define HAZARD_PERF_EN for perf counters
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int NUM_FWD_SRC = 2,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ir_id,
  input  logic [31:0]       ir_ex,
  input  logic [31:0]       ir_mem,
  input  logic              wren_ex,
  input  logic              wren_mem,
  input  logic              br_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);
  localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_STALLS - 1);
  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rs1, mem_rs2, mem_rd;
  logic id_rs1_used, id_rs2_used, id_is_load, ex_rs1_used, ex_rs2_used, ex_is_load;
  logic mem_rs1_used, mem_rs2_used, mem_is_load;
  logic unused_dec;
  logic ex_rd_ok, ex_fwd_ok, mem_fwd_ok, lu;
  fwd_sel_e a_sel, b_sel;
  hz_state_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic stall, flush;
  hazard_src_decode u_dec_id (
    .ir(ir_id), .rs1(id_rs1), .rs2(id_rs2), .rd(id_rd),
    .rs1_used(id_rs1_used), .rs2_used(id_rs2_used), .is_load(id_is_load)
  );
  hazard_src_decode u_dec_ex (
    .ir(ir_ex), .rs1(ex_rs1), .rs2(ex_rs2), .rd(ex_rd),
    .rs1_used(ex_rs1_used), .rs2_used(ex_rs2_used), .is_load(ex_is_load)
  );
  hazard_src_decode u_dec_mem (
    .ir(ir_mem), .rs1(mem_rs1), .rs2(mem_rs2), .rd(mem_rd),
    .rs1_used(mem_rs1_used), .rs2_used(mem_rs2_used), .is_load(mem_is_load)
  );
  assign unused_dec = ^{id_rd, id_is_load, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
                        mem_rs1, mem_rs2, mem_rs1_used, mem_rs2_used, mem_is_load};
  assign ex_rd_ok = ex_rd != 5'd0 && wren_ex;
  assign ex_fwd_ok = ex_rd_ok && !ex_is_load;
  assign mem_fwd_ok = NUM_FWD_SRC == 2 && mem_rd != 5'd0 && wren_mem;
  assign lu = ex_is_load && ex_rd_ok &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  assign a_sel = fwd_pick(id_rs1_used, id_rs1, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
  assign b_sel = fwd_pick(id_rs2_used, id_rs2, ex_fwd_ok, ex_rd, mem_fwd_ok, mem_rd);
  assign fwd_a = rst ? FWD_RF : a_sel;
  assign fwd_b = rst ? FWD_RF : b_sel;
  assign stall_if = !rst && stall;
  assign stall_id = !rst && stall;
  assign flush_id = !rst && flush;
  assign flush_ex = !rst && (stall || flush);
  assign busy = !rst && state != RUN;
  // next state: a taken branch pre-empts everything, load-use only starts from RUN
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall = 1'b0;
    flush = 1'b0;
    if (br_taken) begin
      flush = 1'b1;
      state_n = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_n = FLUSH_CYCLES > 1 ? FL_RELOAD : 4'd0;
    end else if (state == FLUSH) begin
      flush = 1'b1;
      state_n = cnt <= 4'd1 ? RUN : FLUSH;
      cnt_n = cnt - 4'd1;
    end else if (state == LU_STALL) begin
      stall = 1'b1;
      state_n = cnt <= 4'd1 ? RUN : LU_STALL;
      cnt_n = cnt - 4'd1;
    end else if (lu) begin
      stall = 1'b1;
      state_n = LOAD_USE_STALLS > 1 ? LU_STALL : RUN;
      cnt_n = LOAD_USE_STALLS > 1 ? LU_RELOAD : 4'd0;
    end else begin
      state_n = RUN;
    end
  end
  // state and shared down-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= 4'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q, flush_q;
  // saturating counters of load-use stall cycles and accepted branches
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (br_taken && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: table vectors, directed sequences and random stimulus against a remaining-cycles model
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;
  localparam int LUS = 2;
  localparam int FC = 3;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] OP_IMM = 7'b0010011;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] ir_id, ir_ex, ir_mem;
  logic wren_ex, wren_mem, br_taken;
  logic [1:0] fwd_a, fwd_b;
  logic stall_if, stall_id, flush_id, flush_ex, busy;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int m_stall_left = 0;
  int m_flush_left = 0;
  int m_scnt = 0;
  int m_fcnt = 0;
  typedef struct {
    logic [31:0] id, ex, mem;
    logic we_ex, we_mem;
    logic [1:0] fa, fb;
  } vec_t;
  vec_t tbl[12];
  logic [6:0] ops[8];

  hazard_ctrl_unit #(.NUM_FWD_SRC(2), .LOAD_USE_STALLS(LUS), .FLUSH_CYCLES(FC), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .ir_id(ir_id), .ir_ex(ir_ex), .ir_mem(ir_mem),
    .wren_ex(wren_ex), .wren_mem(wren_mem), .br_taken(br_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b010, rd, op};
  endfunction

  function automatic bit uses1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic bit uses2(input logic [6:0] op);
    return op == OP_R || op == OP_S || op == OP_B;
  endfunction

  function automatic int ref_fwd(input logic [4:0] src, input bit used);
    if (!used || src == 5'd0) return 0;
    if (wren_ex && ir_ex[11:7] == src && ir_ex[6:0] != OP_LOAD) return 1;
    if (wren_mem && ir_mem[11:7] == src) return 2;
    return 0;
  endfunction

  function automatic bit ref_lu();
    logic [4:0] d;
    d = ir_ex[11:7];
    return wren_ex && ir_ex[6:0] == OP_LOAD && d != 5'd0 &&
           ((uses1(ir_id[6:0]) && ir_id[19:15] == d) || (uses2(ir_id[6:0]) && ir_id[24:20] == d));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Called just after the falling edge with inputs applied; checks, advances the model, waits one cycle.
  task automatic cycle(input int es = -1, input int efi = -1, input int efe = -1, input int eb = -1);
    bit st, fl, bz;
    int fa, fb;
    st = 1'b0;
    fl = 1'b0;
    #1;
    fa = rst ? 0 : ref_fwd(ir_id[19:15], uses1(ir_id[6:0]));
    fb = rst ? 0 : ref_fwd(ir_id[24:20], uses2(ir_id[6:0]));
    bz = !rst && (m_stall_left > 0 || m_flush_left > 0);
    if (!rst) begin
      chk("perf_stall_cnt", perf_stall_cnt, PERF ? 32'(m_scnt) : 32'd0);
      chk("perf_flush_cnt", perf_flush_cnt, PERF ? 32'(m_fcnt) : 32'd0);
    end
    if (rst) begin
      m_stall_left = 0;
      m_flush_left = 0;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (br_taken) begin
      fl = 1'b1;
      m_flush_left = FC - 1;
      m_stall_left = 0;
      m_fcnt++;
    end else if (m_flush_left > 0) begin
      fl = 1'b1;
      m_flush_left--;
    end else if (m_stall_left > 0) begin
      st = 1'b1;
      m_stall_left--;
      m_scnt++;
    end else if (ref_lu()) begin
      st = 1'b1;
      m_stall_left = LUS - 1;
      m_scnt++;
    end
    chk("fwd_a", 32'(fwd_a), 32'(fa));
    chk("fwd_b", 32'(fwd_b), 32'(fb));
    chk("stall_if", 32'(stall_if), 32'(st));
    chk("stall_id", 32'(stall_id), 32'(st));
    chk("flush_id", 32'(flush_id), 32'(fl));
    chk("flush_ex", 32'(flush_ex), 32'(st | fl));
    chk("busy", 32'(busy), 32'(bz));
    if (es >= 0) chk("seq_stall_if", 32'(stall_if), 32'(es));
    if (efi >= 0) chk("seq_flush_id", 32'(flush_id), 32'(efi));
    if (efe >= 0) chk("seq_flush_ex", 32'(flush_ex), 32'(efe));
    if (eb >= 0) chk("seq_busy", 32'(busy), 32'(eb));
    @(negedge clk);
  endtask

  task automatic idle();
    ir_id = enc(OP_IMM, 0, 0, 0);
    ir_ex = enc(OP_IMM, 0, 0, 0);
    ir_mem = enc(OP_IMM, 0, 0, 0);
    wren_ex = 1'b0;
    wren_mem = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic set_lu();
    ir_ex = enc(OP_LOAD, 9, 1, 0);
    ir_id = enc(OP_R, 10, 9, 2);
    wren_ex = 1'b1;
  endtask

  initial begin
    ops = '{OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_S, OP_B, OP_IMM};
    tbl[0]  = '{enc(OP_R, 6, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_IMM, 0, 0, 0), 1, 0, 2'd1, 2'd1};
    tbl[1]  = '{enc(OP_R, 8, 7, 0), enc(OP_R, 7, 3, 4), enc(OP_IMM, 7, 0, 1), 1, 1, 2'd1, 2'd0};
    tbl[2]  = '{enc(OP_R, 8, 7, 3), enc(OP_R, 3, 1, 1), enc(OP_IMM, 7, 0, 1), 1, 1, 2'd2, 2'd1};
    tbl[3]  = '{enc(OP_LUI, 9, 9, 9), enc(OP_LOAD, 9, 1, 0), enc(OP_IMM, 0, 0, 0), 1, 0, 2'd0, 2'd0};
    tbl[4]  = '{enc(OP_R, 1, 0, 0), enc(OP_R, 0, 1, 2), enc(OP_R, 0, 1, 2), 1, 1, 2'd0, 2'd0};
    tbl[5]  = '{enc(OP_R, 6, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_R, 5, 3, 3), 0, 1, 2'd2, 2'd2};
    tbl[6]  = '{enc(OP_R, 10, 9, 2), enc(OP_LOAD, 9, 1, 0), enc(OP_IMM, 0, 0, 0), 0, 0, 2'd0, 2'd0};
    tbl[7]  = '{enc(OP_IMM, 6, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_IMM, 0, 0, 0), 1, 0, 2'd1, 2'd0};
    tbl[8]  = '{enc(OP_S, 0, 2, 5), enc(OP_R, 5, 1, 2), enc(OP_IMM, 0, 0, 0), 1, 0, 2'd0, 2'd1};
    tbl[9]  = '{enc(OP_JAL, 1, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_IMM, 0, 0, 0), 1, 0, 2'd0, 2'd0};
    tbl[10] = '{enc(OP_B, 0, 5, 7), enc(OP_R, 5, 1, 2), enc(OP_R, 7, 1, 2), 1, 1, 2'd1, 2'd2};
    tbl[11] = '{enc(OP_AUIPC, 3, 5, 5), enc(OP_R, 5, 1, 2), enc(OP_R, 5, 1, 2), 1, 1, 2'd0, 2'd0};
    idle();
    rst = 1'b1;
    @(negedge clk);
    cycle(0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ir_id = tbl[i].id;
      ir_ex = tbl[i].ex;
      ir_mem = tbl[i].mem;
      wren_ex = tbl[i].we_ex;
      wren_mem = tbl[i].we_mem;
      #1;
      chk($sformatf("tbl%0d_fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
      chk($sformatf("tbl%0d_fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
      chk($sformatf("tbl%0d_stall", i), 32'(stall_if), 32'd0);
      cycle();
    end
    idle();
    set_lu();
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 1);
    idle();
    cycle(0, 0, 0, 0);
    br_taken = 1'b1;
    cycle(0, 1, 1, 0);
    br_taken = 1'b0;
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 0, 0);
    br_taken = 1'b1;
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    br_taken = 1'b0;
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 0, 0);
    set_lu();
    br_taken = 1'b1;
    cycle(0, 1, 1, 0);
    br_taken = 1'b0;
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 1);
    cycle(1, 0, 1, 0);
    idle();
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 0);
    set_lu();
    cycle(1, 0, 1, 0);
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    rst = 1'b0;
    idle();
    #1;
    chk("perf_stall_after_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_after_rst", perf_flush_cnt, 32'd0);
    cycle(0, 0, 0, 0);
    set_lu();
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, -1);
    idle();
    #1;
    chk("perf_stall_5", perf_stall_cnt, PERF ? 32'd5 : 32'd0);
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 63) == 0;
      br_taken = $urandom_range(0, 7) == 0;
      wren_ex = $urandom_range(0, 3) != 0;
      wren_mem = $urandom_range(0, 3) != 0;
      ir_id = enc(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ir_ex = enc(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      ir_mem = enc(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised forwarding/stall/flush controller for the RV32I pipeline; next generation of the combinational forwarding/stall unit.
- Adds operand-usage-aware hazard checks, two forwarding sources, multi-cycle load-use stalls and multi-cycle branch flushes, all sequenced by a small FSM.
- Sits beside the ID/EX/MEM pipeline registers. Drives operand mux selects, IF/ID stall enables and ID/EX flush (bubble) controls.

Parameters:
- NUM_FWD_SRC, 2, forwarding sources: 1 = EX only, 2 = EX and MEM/WB.
- LOAD_USE_STALLS, 1, stall cycles per load-use hazard (1..15).
- FLUSH_CYCLES, 1, bubble cycles injected after a taken branch (1..15).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ir_id  in  32  instruction in decode (consumer)
- ir_ex  in  32  instruction in execute
- ir_mem  in  32  instruction in memory/writeback (ignored if NUM_FWD_SRC=1)
- wren_ex  in  1  ir_ex writes the register file
- wren_mem  in  1  ir_mem writes the register file
- br_taken  in  1  taken branch/jump resolved in EX this cycle
- fwd_a  out  2  rs1 select: 0 = regfile, 1 = EX result, 2 = MEM/WB result
- fwd_b  out  2  rs2 select, same encoding
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- flush_id  out  1  clear IF/ID to NOP
- flush_ex  out  1  clear ID/EX to NOP (bubble)
- busy  out  1  FSM not in RUN
- perf_stall_cnt  out  PERF_W  load-use stall cycles
- perf_flush_cnt  out  PERF_W  taken-branch flush events

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Operand usage:
  - rs1 used for all opcodes except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 used only for R (0110011), S (0100011) and B (1100011).
  - rd valid when rd != 0 and the corresponding wren is high.
- Forwarding (combinational, every cycle, including during stalls):
  - Select 1 when the used source equals ir_ex rd, rd is valid, and ir_ex is not a LOAD (0000011).
  - Otherwise select 2 when NUM_FWD_SRC=2 and the source equals ir_mem rd with rd valid.
  - Otherwise select 0.
  - EX has priority over MEM/WB. x0 is never forwarded. An unused source always selects 0.
- Load-use hazard (lu): ir_ex is a LOAD with valid rd, and a used source of ir_id equals that rd.
- FSM states: RUN, LU_STALL, FLUSH. A 4-bit down-counter cnt is shared by the two non-RUN states.
- RUN:
  - br_taken: flush_id=1, flush_ex=1, stall=0. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - Else lu: stall_if=stall_id=1, flush_ex=1. If LOAD_USE_STALLS>1, go to LU_STALL with cnt=LOAD_USE_STALLS-1.
  - Else all controls are 0.
- LU_STALL:
  - Asserts stall_if, stall_id and flush_ex, and decrements cnt.
  - Returns to RUN when cnt reaches 1 after that cycle's assertion.
  - br_taken here aborts the stall and is handled exactly as br_taken in RUN.
- FLUSH:
  - Asserts flush_id and flush_ex, and decrements cnt. Returns to RUN after the last cycle.
  - A new br_taken reloads cnt=FLUSH_CYCLES-1.
  - lu is ignored in FLUSH.
- Simultaneous br_taken and lu: br_taken wins (older instruction). No stall is issued.
- Reset values:
  - While rst is high, all control outputs are 0, fwd_a and fwd_b are 0, and busy is 0.
  - State becomes RUN and cnt becomes 0 on the next edge.
  - A reset mid-stall or mid-flush aborts the sequence.
- busy = (state != RUN).

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with stall_if=1 from lu.
  - perf_flush_cnt increments on each accepted br_taken.
  - Both saturate at all-ones and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops are built. Ports exist in both builds.

Decomposition:
- Package hazard_pkg:
  - opcode constants (OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_S, OP_B)
  - fwd_sel_e enum (FWD_RF, FWD_EX, FWD_MEM)
  - hz_state_e enum (RUN, LU_STALL, FLUSH)
- Sub-module hazard_src_decode: one 32-bit instruction in; rs1, rs2, rd, rs1_used, rs2_used and is_load out. Instantiated once per stage.

Test Plan:
- ir_ex=add x5,x1,x2 (wren_ex=1), ir_id=sub x6,x5,x5 -> fwd_a=1, fwd_b=1, no stall.
- ir_mem=addi x7,x0,1 (wren_mem=1), ir_ex=add x7,x3,x4 (wren_ex=1), ir_id=add x8,x7,x0 -> fwd_a=1 (EX priority), fwd_b=0.
- LOAD_USE_STALLS=2; ir_ex=lw x9,0(x1), ir_id=add x10,x9,x2 -> stall_if, stall_id and flush_ex high for exactly 2 cycles, busy high in cycle 2 only.
- FLUSH_CYCLES=3; br_taken pulse -> flush_id=flush_ex=1 for 3 cycles. Second br_taken in cycle 2 -> flush extends to 3 cycles from the new pulse.
- Same cycle br_taken=1 and load-use pending -> flush only, stall_if=0. ir_id=lui x9,1 behind lw x9 -> no stall.
- rst=1 during LU_STALL -> outputs 0 that cycle, busy=0 after. With HAZARD_PERF_EN, counters read 0 after reset and 5 after 5 stall cycles.
